// File: rtl/wfg_stim_sweep_ctrl_if.sv
// Signal bundle between the register block / sine stimulus and the sweep sequencer.
// The sweep_cnt_o member exists only when WFG_STIM_SWEEP_CNT_EN is defined.
interface wfg_stim_sweep_ctrl_if #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned INC_W   = 16
);
  logic               sweep_start_i;
  logic               sweep_stop_i;
  logic [INC_W-1:0]   start_inc_q_i;
  logic [INC_W-1:0]   stop_inc_q_i;
  logic [INC_W-1:0]   step_inc_q_i;
  logic [DWELL_W-1:0] dwell_q_i;
  logic [1:0]         mode_q_i;
  logic               stim_tvalid_i;
  logic               stim_tready_i;
  logic               ctrl_en_o;
  logic [INC_W-1:0]   inc_val_o;
  logic               busy_o;
  logic               done_o;
`ifdef WFG_STIM_SWEEP_CNT_EN
  logic [15:0]        sweep_cnt_o;
`endif

  // master: the sweep sequencer
  modport master (
`ifdef WFG_STIM_SWEEP_CNT_EN
    output sweep_cnt_o,
`endif
    input  sweep_start_i, sweep_stop_i, start_inc_q_i, stop_inc_q_i, step_inc_q_i,
    input  dwell_q_i, mode_q_i, stim_tvalid_i, stim_tready_i,
    output ctrl_en_o, inc_val_o, busy_o, done_o
  );

  // slave: register block and stream monitor side
  modport slave (
`ifdef WFG_STIM_SWEEP_CNT_EN
    input  sweep_cnt_o,
`endif
    output sweep_start_i, sweep_stop_i, start_inc_q_i, stop_inc_q_i, step_inc_q_i,
    output dwell_q_i, mode_q_i, stim_tvalid_i, stim_tready_i,
    input  ctrl_en_o, inc_val_o, busy_o, done_o
  );
endinterface

// File: rtl/wfg_stim_sweep_ctrl.sv
// Frequency-sweep sequencer stepping the sine increment once per dwell of delivered samples.
// Optional macro WFG_STIM_SWEEP_CNT_EN adds a saturating count of completed top-of-sweep dwells.
module wfg_stim_sweep_ctrl #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned INC_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  wfg_stim_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e             state_q, state_d;
  logic [INC_W-1:0]   inc_q, inc_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [INC_W-1:0]   start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         mode_q;

  logic               accept_start, sample, dwell_done, at_top, at_bottom, single_mode;
  logic [INC_W-1:0]   step_eff, up_next, dn_next;
  logic [DWELL_W-1:0] dwell_eff;
  logic [INC_W:0]     up_sum, dn_diff;

  assign accept_start = (state_q == StIdle) && bus.sweep_start_i && !bus.sweep_stop_i;
  // A handshake coinciding with an abort is deliberately dropped.
  assign sample       = (state_q != StIdle) && bus.stim_tvalid_i && bus.stim_tready_i &&
                        !bus.sweep_stop_i;
  assign step_eff     = (step_q == '0) ? INC_W'(1) : step_q;
  assign dwell_eff    = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign dwell_done   = sample && (({1'b0, cnt_q} + (DWELL_W+1)'(1)) >= {1'b0, dwell_eff});
  assign at_top       = inc_q >= stop_q;
  assign at_bottom    = inc_q <= start_q;
  assign single_mode  = (mode_q != 2'd1) && (mode_q != 2'd2);

  assign up_sum  = {1'b0, inc_q} + {1'b0, step_eff};
  assign up_next = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[INC_W-1:0];
  assign dn_diff = {1'b0, inc_q} - {1'b0, step_eff};
  assign dn_next = (dn_diff[INC_W] || (dn_diff[INC_W-1:0] < start_q)) ? start_q
                                                                       : dn_diff[INC_W-1:0];

  // Shadow copies; stop is raised to start so start >= stop collapses to a single point.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= '0;
    end else if (accept_start) begin
      start_q <= bus.start_inc_q_i;
      stop_q  <= (bus.stop_inc_q_i < bus.start_inc_q_i) ? bus.start_inc_q_i : bus.stop_inc_q_i;
      step_q  <= bus.step_inc_q_i;
      dwell_q <= bus.dwell_q_i;
      mode_q  <= bus.mode_q_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      inc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept_start) begin
          state_d = StUp;
          inc_d   = bus.start_inc_q_i;
          cnt_d   = '0;
        end
      end
      StUp: begin
        if (dwell_done) begin
          cnt_d = '0;
          if (!at_top) begin
            inc_d = up_next;
          end else if (mode_q == 2'd1) begin
            inc_d = start_q;
          end else if (mode_q == 2'd2) begin
            state_d = StDown;
            inc_d   = dn_next;
          end else begin
            state_d = StIdle;
            done_d  = single_mode;
          end
        end else if (sample) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      StDown: begin
        if (dwell_done) begin
          cnt_d = '0;
          if (at_bottom) begin
            state_d = StUp;
            inc_d   = up_next;
          end else begin
            inc_d = dn_next;
          end
        end else if (sample) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.sweep_stop_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign bus.ctrl_en_o = (state_q != StIdle);
  assign bus.busy_o    = (state_q != StIdle);
  assign bus.inc_val_o = inc_q;
  assign bus.done_o    = done_q;

`ifdef WFG_STIM_SWEEP_CNT_EN
  logic        top_hit;
  logic [15:0] sweep_cnt_q;

  assign top_hit = (state_q == StUp) && dwell_done && at_top;

  always_ff @(posedge clk) begin
    if (rst || accept_start) begin
      sweep_cnt_q <= '0;
    end else if (top_hit && (sweep_cnt_q != 16'hFFFF)) begin
      sweep_cnt_q <= sweep_cnt_q + 16'd1;
    end
  end

  assign bus.sweep_cnt_o = sweep_cnt_q;
`endif

endmodule

// File: tb/tb_wfg_stim_sweep_ctrl.sv
// Self-checking bench: expected increment sequences are built from the sweep rules as value lists.
// Define WFG_STIM_SWEEP_CNT_EN to also exercise the sweep counter.
`timescale 1ns/1ps
module tb_wfg_stim_sweep_ctrl;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned INC_W   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wfg_stim_sweep_ctrl_if #(.DWELL_W(DWELL_W), .INC_W(INC_W)) bus ();

  wfg_stim_sweep_ctrl #(.DWELL_W(DWELL_W), .INC_W(INC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_pass  = 0;
  int n_total = 0;
  int hs;
  int exp_q[$];

  // Visited increments: the upward list, then (by mode) restarts or alternating down/up legs.
  function automatic void build_seq(int s, int e, int st, int md, int n);
    int ups[$];
    int dns[$];
    int v;
    exp_q.delete();
    if (st == 0) st = 1;
    if (s >= e) begin
      exp_q.push_back(s);
      if (md == 1 || md == 2) while (exp_q.size() < n) exp_q.push_back(s);
      return;
    end
    v = s;
    while (1) begin
      ups.push_back(v);
      if (v == e) break;
      v = (v + st > e) ? e : v + st;
    end
    v = e;
    while (1) begin
      dns.push_back(v);
      if (v == s) break;
      v = (v - st < s) ? s : v - st;
    end
    foreach (ups[i]) exp_q.push_back(ups[i]);
    if (md == 0 || md == 3) return;
    while (exp_q.size() < n) begin
      if (md == 1) begin
        foreach (ups[i]) exp_q.push_back(ups[i]);
      end else begin
        for (int i = 1; i < dns.size(); i++) exp_q.push_back(dns[i]);
        for (int i = 1; i < ups.size(); i++) exp_q.push_back(ups[i]);
      end
    end
  endfunction

  task automatic drive(bit v, bit r);
    bus.stim_tvalid_i = v;
    bus.stim_tready_i = r;
    @(posedge clk);
    #1;
    if (v && r) hs++;
  endtask

  // Pulses start, then scrambles the register inputs to show they are shadowed.
  task automatic start_sweep(int s, int e, int st, int dw, int md);
    bus.start_inc_q_i = 16'(s);
    bus.stop_inc_q_i  = 16'(e);
    bus.step_inc_q_i  = 16'(st);
    bus.dwell_q_i     = 16'(dw);
    bus.mode_q_i      = 2'(md);
    bus.sweep_start_i = 1'b1;
    drive(1'b0, 1'b0);
    bus.sweep_start_i = 1'b0;
    bus.start_inc_q_i = 16'($urandom);
    bus.stop_inc_q_i  = 16'($urandom);
    bus.step_inc_q_i  = 16'($urandom);
    bus.dwell_q_i     = 16'($urandom);
    bus.mode_q_i      = 2'($urandom);
    hs = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.sweep_start_i = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_total++;
      if ({bus.busy_o, bus.ctrl_en_o, bus.done_o, bus.inc_val_o} !== 19'h0)
        $display("FAIL reset_state: got %h expected 0", {bus.busy_o, bus.ctrl_en_o, bus.done_o,
                 bus.inc_val_o});
      else n_pass++;
    end
`ifdef WFG_STIM_SWEEP_CNT_EN
    n_total++;
    if (bus.sweep_cnt_o !== 16'h0) $display("FAIL reset_cnt: got %h expected 0", bus.sweep_cnt_o);
    else n_pass++;
`endif
    bus.sweep_start_i = 1'b0;
    rst = 1'b0;
    drive(1'b0, 1'b0);
    // Reset in the middle of a sweep aborts silently.
    start_sweep(10, 50, 10, 1, 0);
    drive(1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({bus.busy_o, bus.ctrl_en_o, bus.done_o, bus.inc_val_o} !== 19'h0)
        $display("FAIL reset_mid_sweep: got %h expected 0", {bus.busy_o, bus.ctrl_en_o,
                 bus.done_o, bus.inc_val_o});
      else n_pass++;
      drive(1'b1, 1'b1);
    end
  endtask

  task automatic test_single_sweep(int s, int e, int st, int dw, bit rnd);
    int dwe;
    int total;
    int guard;
    int last;
    dwe = (dw == 0) ? 1 : dw;
    build_seq(s, e, st, 0, 0);
    start_sweep(s, e, st, dw, 0);
    total = exp_q.size() * dwe;
    last  = exp_q[exp_q.size() - 1];
    guard = 0;
    while (hs < total && guard < 4000) begin
      n_total++;
      if ({bus.busy_o, bus.ctrl_en_o, bus.done_o, bus.inc_val_o} !== {3'b110, 16'(exp_q[hs/dwe])})
        $display("FAIL single_step hs=%0d: got %h expected %h", hs, {bus.busy_o, bus.ctrl_en_o,
                 bus.done_o, bus.inc_val_o}, {3'b110, 16'(exp_q[hs/dwe])});
      else n_pass++;
      if (rnd) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else drive(1'b1, 1'b1);
      guard++;
    end
    n_total++;
    if (guard >= 4000) $display("FAIL single_timeout: got %0d handshakes required %0d", hs, total);
    else n_pass++;
    n_total++;
    if ({bus.busy_o, bus.ctrl_en_o, bus.done_o, bus.inc_val_o} !== {3'b001, 16'(last)})
      $display("FAIL single_done: got %h expected %h", {bus.busy_o, bus.ctrl_en_o, bus.done_o,
               bus.inc_val_o}, {3'b001, 16'(last)});
    else n_pass++;
    drive(1'b1, 1'b1);
    n_total++;
    if ({bus.busy_o, bus.ctrl_en_o, bus.done_o, bus.inc_val_o} !== {3'b000, 16'(last)})
      $display("FAIL single_after_done: got %h expected %h", {bus.busy_o, bus.ctrl_en_o,
               bus.done_o, bus.inc_val_o}, {3'b000, 16'(last)});
    else n_pass++;
  endtask

  // Repeat / ping-pong run, aborted on a handshake that would otherwise complete a dwell.
  task automatic test_cyclic(int s, int e, int st, int dw, int md, int nsteps, bit rnd);
    int dwe;
    int guard;
    int held;
    dwe = (dw == 0) ? 1 : dw;
    build_seq(s, e, st, md, nsteps + 2);
    start_sweep(s, e, st, dw, md);
    guard = 0;
    while (hs < nsteps * dwe - 1 && guard < 4000) begin
      n_total++;
      if ({bus.busy_o, bus.ctrl_en_o, bus.done_o, bus.inc_val_o} !== {3'b110, 16'(exp_q[hs/dwe])})
        $display("FAIL cyclic_step mode=%0d hs=%0d: got %h expected %h", md, hs, {bus.busy_o,
                 bus.ctrl_en_o, bus.done_o, bus.inc_val_o}, {3'b110, 16'(exp_q[hs/dwe])});
      else n_pass++;
      if (rnd) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else drive(1'b1, 1'b1);
      guard++;
    end
    held = exp_q[hs/dwe];
    bus.sweep_stop_i = 1'b1;
    drive(1'b1, 1'b1);
    bus.sweep_stop_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({bus.busy_o, bus.ctrl_en_o, bus.done_o, bus.inc_val_o} !== {3'b000, 16'(held)})
        $display("FAIL cyclic_stop mode=%0d: got %h expected %h", md, {bus.busy_o, bus.ctrl_en_o,
                 bus.done_o, bus.inc_val_o}, {3'b000, 16'(held)});
      else n_pass++;
      drive(1'b1, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    int exp_inc[10] = '{100, 100, 100, 100, 100, 100, 100, 100, 200, 200};
    bit rdy[10]     = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    bit vld[10]     = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    start_sweep(100, 300, 100, 3, 0);
    for (int i = 0; i < 10; i++) begin
      drive(vld[i], rdy[i]);
      n_total++;
      if (bus.inc_val_o !== 16'(exp_inc[i]))
        $display("FAIL backpressure cyc=%0d: got %h expected %h", i, bus.inc_val_o,
                 16'(exp_inc[i]));
      else n_pass++;
    end
    bus.sweep_stop_i = 1'b1;
    drive(1'b0, 1'b0);
    bus.sweep_stop_i = 1'b0;
  endtask

  task automatic test_start_while_busy();
    build_seq(10, 50, 10, 0, 0);
    start_sweep(10, 50, 10, 1, 0);
    drive(1'b1, 1'b1);
    bus.start_inc_q_i = 16'h1000;
    bus.sweep_start_i = 1'b1;
    drive(1'b1, 1'b1);
    bus.sweep_start_i = 1'b0;
    for (int i = 2; i < 5; i++) begin
      n_total++;
      if ({bus.busy_o, bus.inc_val_o} !== {1'b1, 16'(exp_q[i])})
        $display("FAIL start_while_busy step=%0d: got %h expected %h", i, {bus.busy_o,
                 bus.inc_val_o}, {1'b1, 16'(exp_q[i])});
      else n_pass++;
      drive(1'b1, 1'b1);
    end
    n_total++;
    if ({bus.busy_o, bus.done_o} !== 2'b01)
      $display("FAIL start_while_busy_done: got %b expected 01", {bus.busy_o, bus.done_o});
    else n_pass++;
    drive(1'b0, 1'b0);
  endtask

  task automatic test_simul_start_stop();
    bus.start_inc_q_i = 16'h0040;
    bus.stop_inc_q_i  = 16'h0080;
    bus.sweep_start_i = 1'b1;
    bus.sweep_stop_i  = 1'b1;
    drive(1'b1, 1'b1);
    bus.sweep_start_i = 1'b0;
    bus.sweep_stop_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({bus.busy_o, bus.ctrl_en_o, bus.done_o} !== 3'b000)
        $display("FAIL simul_start_stop: got %b expected 000", {bus.busy_o, bus.ctrl_en_o,
                 bus.done_o});
      else n_pass++;
      drive(1'b1, 1'b1);
    end
  endtask

`ifdef WFG_STIM_SWEEP_CNT_EN
  task automatic test_sweep_cnt();
    start_sweep(10, 30, 10, 1, 1);
    n_total++;
    if (bus.sweep_cnt_o !== 16'd0) $display("FAIL sweep_cnt_start: got %0d expected 0",
                                            bus.sweep_cnt_o);
    else n_pass++;
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1);
    n_total++;
    if ({bus.sweep_cnt_o, bus.inc_val_o} !== {16'd3, 16'd10})
      $display("FAIL sweep_cnt_repeat: got %h expected %h", {bus.sweep_cnt_o, bus.inc_val_o},
               {16'd3, 16'd10});
    else n_pass++;
    bus.sweep_stop_i = 1'b1;
    drive(1'b0, 1'b0);
    bus.sweep_stop_i = 1'b0;
  endtask
`endif

  initial begin
    int s, e, st, span, md;
    rst = 1'b1;
    bus.sweep_start_i = 1'b0;
    bus.sweep_stop_i  = 1'b0;
    bus.start_inc_q_i = '0;
    bus.stop_inc_q_i  = '0;
    bus.step_inc_q_i  = '0;
    bus.dwell_q_i     = '0;
    bus.mode_q_i      = '0;
    bus.stim_tvalid_i = 1'b0;
    bus.stim_tready_i = 1'b0;
    hs = 0;

    test_reset();
    test_single_sweep(16'h0100, 16'h0400, 16'h0100, 2, 1'b0);
    test_cyclic(16'hFF00, 16'hFFF0, 16'h0080, 1, 1, 8, 1'b0);
    test_cyclic(10, 30, 10, 1, 2, 9, 1'b0);
    test_backpressure();
    test_single_sweep(5, 8, 0, 0, 1'b0);
    test_single_sweep(300, 200, 7, 2, 1'b1);
    test_start_while_busy();
    test_simul_start_stop();
`ifdef WFG_STIM_SWEEP_CNT_EN
    test_sweep_cnt();
`endif
    for (int k = 0; k < 12; k++) begin
      s    = int'($urandom_range(0, 65535));
      e    = int'($urandom_range(0, 65535));
      span = (e > s) ? e - s : 0;
      st   = span / int'($urandom_range(1, 6)) + int'($urandom_range(0, 50));
      if (st > 65535) st = 65535;
      md   = int'($urandom_range(0, 3));
      if (md == 0 || md == 3) test_single_sweep(s, e, st, int'($urandom_range(0, 3)), 1'b1);
      else test_cyclic(s, e, st, int'($urandom_range(0, 3)), md, 15, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
